// File: rtl/conv_stream_engine_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the streaming convolution engine:
//     - state_t    : frame-control FSM states
//     - clog2()    : ceiling log2 for elaboration-time width calculation
//     - acc_width(): result width, 2*DATA_W + clog2(K_SIZE*K_SIZE), which is
//                    just wide enough to hold K_SIZE^2 full-scale products
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int acc_width(input int data_w, input int k_size);
        return 2 * data_w + clog2(k_size * k_size);
    endfunction

endpackage

// File: rtl/conv_stream_engine_if.sv
// ---------------------------------------------------------------------------
// conv_stream_engine_if
//   Pixel-in / result-out valid-ready streams of the convolution engine.
//     in_valid, in_ready, pixel_in    : raster-order pixel stream into engine
//     out_valid, out_ready, pixel_out : convolution result stream out of engine
//   Modports:
//     master : the environment (feeds pixels, consumes results)
//     slave  : the engine
// ---------------------------------------------------------------------------
interface conv_stream_engine_if
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = acc_width(8, 3)
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pixel_in;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  pixel_out;

    modport master (
        output in_valid,
        output pixel_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  pixel_out
    );

    modport slave (
        input  in_valid,
        input  pixel_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output pixel_out
    );

endinterface

// File: rtl/conv_stream_engine_approx_mult.sv
// ---------------------------------------------------------------------------
// approx_mult
//   Unsigned DATA_W x DATA_W multiplier with optional approximate mode in
//   which the TRUNC_BITS least significant bits of the pixel operand are
//   forced to zero before multiplying.
//   Build option: macro APPROX_MUL_EN. When undefined the truncation logic is
//   not built and approx_i has no effect (every product is exact).
//   Ports:
//     a_i      : pixel operand
//     b_i      : kernel coefficient operand
//     approx_i : 1 = approximate product, 0 = exact product
//     p_o      : 2*DATA_W-bit product (combinational)
// ---------------------------------------------------------------------------
module approx_mult
    import conv_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TRUNC_BITS = 2
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic                approx_i,
    output logic [2*DATA_W-1:0] p_o
);

    localparam int PW = 2 * DATA_W;

    logic [DATA_W-1:0] a_eff;

`ifdef APPROX_MUL_EN
    // Ones above the truncated field; the shift also covers TRUNC_BITS == 0.
    localparam logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b1}} << TRUNC_BITS;

    assign a_eff = approx_i ? (a_i & KEEP_MASK) : a_i;
`else
    // Mode input is deliberately ignored in the exact-only build.
    logic unused_approx;
    assign unused_approx = approx_i;
    assign a_eff         = a_i;
`endif

    assign p_o = PW'(a_eff) * PW'(b_i);

endmodule

// File: rtl/conv_stream_engine.sv
// ---------------------------------------------------------------------------
// conv_stream_engine
//   Streaming K_SIZE x K_SIZE "valid" 2-D convolution over an IMG_W x IMG_H
//   raster frame. Pixels arrive one per handshake; one result is emitted per
//   full window in raster order. Results appear two cycles after the pixel
//   that completes their window (product register, then adder-tree register).
//   Build option: macro APPROX_MUL_EN enables the approximate-product path
//   selected by the approx input (latched at start).
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous reset, active low
//     start     : one-cycle pulse in IDLE begins a frame; ignored otherwise
//     approx    : product mode, latched on start
//     kernel    : coefficients, coefficient 0 in the MSBs, row-major;
//                 latched on start
//     strm      : pixel-in / result-out streams (slave modport)
//     busy      : high whenever the FSM is not IDLE
//     done      : one-cycle pulse when the frame has been fully delivered
// ---------------------------------------------------------------------------
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int K_SIZE     = 3,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int TRUNC_BITS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            approx,
    input  logic [DATA_W*K_SIZE*K_SIZE-1:0] kernel,
    conv_stream_engine_if.slave             strm,
    output logic                            busy,
    output logic                            done
);

    localparam int KK    = K_SIZE * K_SIZE;
    localparam int ACC_W = acc_width(DATA_W, K_SIZE);
    localparam int PW    = 2 * DATA_W;
    localparam int CW    = clog2(IMG_W);
    localparam int RW    = clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K_SIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K_SIZE - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d, rd_addr;
    logic [RW-1:0]        row_q, row_d;
    logic [DATA_W*KK-1:0] kernel_q;
    logic                 approx_q;

    logic stall, in_ready, accept;
    logic last_col, last_row, win_full;

    // Line-buffer read data (index 0 = most recent complete row).
    logic [DATA_W-1:0] rd_data  [K_SIZE-1];
    // Incoming window column, top row first.
    logic [DATA_W-1:0] new_col  [K_SIZE];
    // Previous K_SIZE-1 window columns, oldest first.
    logic [DATA_W-1:0] win_q    [K_SIZE][K_SIZE-1];
    logic [DATA_W-1:0] win_elem [KK];
    logic [DATA_W-1:0] coef     [KK];

    logic [PW-1:0]    prod_d [KK];
    logic [PW-1:0]    prod_q [KK];
    logic             s1_valid_q;
    logic [ACC_W-1:0] sum_d;
    logic             out_valid_q;
    logic [ACC_W-1:0] pixel_out_q;

    // -----------------------------------------------------------------------
    // Handshake and position decode
    // -----------------------------------------------------------------------
    // A held result freezes every stage, including pixel intake.
    assign stall    = out_valid_q && !strm.out_ready;
    assign in_ready = (state_q == RUN) && !stall;
    assign accept   = strm.in_valid && in_ready;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign win_full = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);

    // -----------------------------------------------------------------------
    // Frame FSM and raster counters
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    col_d = last_col ? '0 : col_q + 1'b1;
                    if (last_col) begin
                        row_d = last_row ? '0 : row_q + 1'b1;
                        if (last_row) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (!s1_valid_q && !out_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Line buffers: one RAM per stored row with a registered read port.
    // The read address is always the column of the next pixel to arrive, so
    // rd_data is ready when that pixel is accepted. The write (current column)
    // and the read (next column) never collide because IMG_W >= 3.
    // Row k receives the word row k-1 held at that column, cascading rows.
    // -----------------------------------------------------------------------
    assign rd_addr = rst ? col_d : '0;

    genvar gi;
    generate
        for (gi = 0; gi < K_SIZE - 1; gi++) begin : g_line
            logic [DATA_W-1:0] mem [IMG_W];
            logic [DATA_W-1:0] wr_data;
            logic [DATA_W-1:0] rd_q;

            if (gi == 0) begin : g_head
                assign wr_data = strm.pixel_in;
            end else begin : g_tail
                assign wr_data = rd_data[gi-1];
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[col_q] <= wr_data;
                end
                rd_q <= mem[rd_addr];
            end

            assign rd_data[gi] = rd_q;
        end

        // Newest column of the window: oldest stored row on top, live pixel
        // at the bottom.
        for (gi = 0; gi < K_SIZE; gi++) begin : g_col
            if (gi == K_SIZE - 1) begin : g_live
                assign new_col[gi] = strm.pixel_in;
            end else begin : g_stored
                assign new_col[gi] = rd_data[K_SIZE-2-gi];
            end
        end

        // Window element i = row*K_SIZE + col; the right-most column is the
        // one being accepted right now, so products start the same cycle.
        for (gi = 0; gi < KK; gi++) begin : g_tap
            localparam int R = gi / K_SIZE;
            localparam int C = gi % K_SIZE;

            if (C == K_SIZE - 1) begin : g_new
                assign win_elem[gi] = new_col[R];
            end else begin : g_old
                assign win_elem[gi] = win_q[R][C];
            end

            assign coef[gi] = kernel_q[(KK-1-gi)*DATA_W +: DATA_W];

            approx_mult #(
                .DATA_W    (DATA_W),
                .TRUNC_BITS(TRUNC_BITS)
            ) u_mult (
                .a_i     (win_elem[gi]),
                .b_i     (coef[gi]),
                .approx_i(approx_q),
                .p_o     (prod_d[gi])
            );
        end
    endgenerate

    // Adder tree feeding the output register.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < KK; i++) begin
            sum_d = sum_d + ACC_W'(prod_q[i]);
        end
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            kernel_q    <= '0;
            approx_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pixel_out_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if ((state_q == IDLE) && start) begin
                kernel_q <= kernel;
                approx_q <= approx;
            end
            if (!stall) begin
                s1_valid_q  <= accept && win_full;
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    pixel_out_q <= sum_d;
                end
            end
        end
    end

    // Datapath registers without reset: the window is refilled before any
    // result depends on it, and products are qualified by s1_valid_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K_SIZE; r++) begin
                for (int c = 0; c < K_SIZE - 2; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K_SIZE-2] <= new_col[r];
            end
            for (int i = 0; i < KK; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign strm.in_ready  = in_ready;
    assign strm.out_valid = out_valid_q;
    assign strm.pixel_out = pixel_out_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_conv_stream_engine.sv
module tb_conv_stream_engine;
    import conv_pkg::*;

    localparam int DATA_W     = 8;
    localparam int K_SIZE     = 3;
    localparam int IMG_W      = 4;
    localparam int IMG_H      = 4;
    localparam int TRUNC_BITS = 2;
    localparam int KK         = K_SIZE * K_SIZE;
    localparam int ACC_W      = acc_width(DATA_W, K_SIZE);
    localparam int NPIX       = IMG_W * IMG_H;
    localparam int NOUT       = (IMG_W - K_SIZE + 1) * (IMG_H - K_SIZE + 1);

`ifdef APPROX_MUL_EN
    localparam bit APPROX_BUILT = 1'b1;
`else
    localparam bit APPROX_BUILT = 1'b0;
`endif

    logic                 clk    = 1'b0;
    logic                 rst    = 1'b0;
    logic                 start  = 1'b0;
    logic                 approx = 1'b0;
    logic [DATA_W*KK-1:0] kernel = '0;
    logic                 busy;
    logic                 done;

    conv_stream_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) ifc ();

    conv_stream_engine #(
        .DATA_W    (DATA_W),
        .K_SIZE    (K_SIZE),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .TRUNC_BITS(TRUNC_BITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .approx(approx),
        .kernel(kernel),
        .strm  (ifc),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int               frame_pix [NPIX];
    int               kern      [KK];
    logic [ACC_W-1:0] exp_q     [$];

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [DATA_W*KK-1:0] pack_kernel();
        logic [DATA_W*KK-1:0] v;
        v = '0;
        for (int i = 0; i < KK; i++) v[(KK-1-i)*DATA_W +: DATA_W] = DATA_W'(kern[i]);
        return v;
    endfunction

    // Reference: direct valid-mode 2-D convolution over the stored frame.
    function automatic void build_expected(input bit apx);
        int     mask;
        longint acc;
        mask = apx ? ~((1 << TRUNC_BITS) - 1) : -1;
        exp_q.delete();
        for (int r = 0; r <= IMG_H - K_SIZE; r++) begin
            for (int c = 0; c <= IMG_W - K_SIZE; c++) begin
                acc = 0;
                for (int kr = 0; kr < K_SIZE; kr++)
                    for (int kc = 0; kc < K_SIZE; kc++)
                        acc += longint'(kern[kr*K_SIZE+kc]) *
                               longint'(frame_pix[(r+kr)*IMG_W + c + kc] & mask);
                exp_q.push_back(ACC_W'(acc));
            end
        end
    endfunction

    // rdy_mode: 0 = always ready, 1 = random, 2 = hold first result 5 cycles
    task automatic run_frame(input string name, input bit apx, input int rdy_mode,
                             input bit rand_valid, input bit disturb);
        int pix_idx = 0, got = 0, cyc = 0, hold_cnt = 0, acc_cyc = -1;
        bit prev_stall = 0, done_seen = 0, finished = 0, disturbed = 0, seen_out = 0;
        bit in_fire, out_fire;
        logic [ACC_W-1:0] prev_val = '0;
        logic [ACC_W-1:0] exp_v;
        build_expected(apx && APPROX_BUILT);
        kernel = pack_kernel();
        approx = apx;
        while (!finished && cyc < 2000) begin
            start = (cyc == 0);
            if (disturb && !disturbed && pix_idx == 5) begin
                start     = 1'b1;
                kernel    = ~kernel;
                approx    = ~approx;
                disturbed = 1'b1;
            end
            ifc.in_valid = (pix_idx < NPIX) && (!rand_valid || $urandom_range(0, 3) != 0);
            ifc.pixel_in = (pix_idx < NPIX) ? DATA_W'(frame_pix[pix_idx]) : '0;
            case (rdy_mode)
                0:       ifc.out_ready = 1'b1;
                1:       ifc.out_ready = 1'($urandom_range(0, 1));
                default: ifc.out_ready = (got > 0) || (hold_cnt >= 5);
            endcase
            #1;
            if (done_seen) begin
                check({name, "/done_width"}, ACC_W'(done), '0);
                check({name, "/busy_fall"}, ACC_W'(busy), '0);
                finished = 1'b1;
            end else begin
                if (cyc == 0) check({name, "/ready_idle"}, ACC_W'(ifc.in_ready), '0);
                if (prev_stall) begin
                    check({name, "/hold_valid"}, ACC_W'(ifc.out_valid), ACC_W'(1));
                    check({name, "/hold_data"}, ifc.pixel_out, prev_val);
                end
                if (ifc.out_valid && !ifc.out_ready) begin
                    check({name, "/ready_in_stall"}, ACC_W'(ifc.in_ready), '0);
                    if (rdy_mode == 2 && got == 0) hold_cnt++;
                end
                if (ifc.out_valid && !seen_out) begin
                    seen_out = 1'b1;
                    check({name, "/latency"}, ACC_W'(cyc - acc_cyc), ACC_W'(2));
                end
                in_fire  = ifc.in_valid && ifc.in_ready;
                out_fire = ifc.out_valid && ifc.out_ready;
                if (out_fire) begin
                    if (exp_q.size() == 0) begin
                        check({name, "/extra_result"}, ACC_W'(got + 1), ACC_W'(NOUT));
                    end else begin
                        exp_v = exp_q.pop_front();
                        $display("%s: result %0d = %0d (model %0d)", name, got, ifc.pixel_out, exp_v);
                        check({name, "/result"}, ifc.pixel_out, exp_v);
                    end
                    got++;
                end
                if (done) begin
                    done_seen = 1'b1;
                    check({name, "/count_at_done"}, ACC_W'(got), ACC_W'(NOUT));
                    check({name, "/pixels_at_done"}, ACC_W'(pix_idx), ACC_W'(NPIX));
                end
                prev_stall = ifc.out_valid && !ifc.out_ready;
                prev_val   = ifc.pixel_out;
                if (in_fire) begin
                    if (pix_idx == (K_SIZE-1)*IMG_W + K_SIZE - 1) acc_cyc = cyc;
                    pix_idx++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        start         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        check({name, "/frame_completed"}, ACC_W'(finished), ACC_W'(1));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "/busy"}, ACC_W'(busy), '0);
        check({name, "/done"}, ACC_W'(done), '0);
        check({name, "/out_valid"}, ACC_W'(ifc.out_valid), '0);
        check({name, "/in_ready"}, ACC_W'(ifc.in_ready), '0);
        check({name, "/pixel_out"}, ifc.pixel_out, '0);
    endtask

    initial begin
        int accepted, guard;
        ifc.in_valid  = 1'b0;
        ifc.pixel_in  = '0;
        ifc.out_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
        @(negedge clk);

        // Ramp 1..16, unit kernel: 54, 63, 90, 99
        for (int i = 0; i < NPIX; i++) frame_pix[i] = i + 1;
        for (int i = 0; i < KK; i++) kern[i] = 1;
        run_frame("ramp", 1'b0, 0, 1'b0, 1'b0);

        // Descending kernel on a flat frame: every result 450
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 10;
        for (int i = 0; i < KK; i++) kern[i] = 9 - i;
        run_frame("flat10", 1'b0, 0, 1'b0, 1'b0);

        // Full-scale pixels, accurate then approximate
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 255;
        for (int i = 0; i < KK; i++) kern[i] = 1;
        run_frame("sat_exact", 1'b0, 0, 1'b0, 1'b0);
        run_frame("sat_approx", 1'b1, 0, 1'b0, 1'b0);

        // First result held off for 5 cycles
        for (int i = 0; i < NPIX; i++) frame_pix[i] = i + 1;
        run_frame("hold5", 1'b0, 2, 1'b0, 1'b0);

        // Extra start pulse and kernel/approx change mid-frame
        run_frame("disturb", 1'b0, 0, 1'b0, 1'b1);

        // Reset after 7 pixels, then a clean frame
        kernel = pack_kernel();
        approx = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        accepted = 0;
        guard    = 0;
        while (accepted < 7 && guard < 100) begin
            ifc.in_valid = 1'b1;
            ifc.pixel_in = DATA_W'(frame_pix[accepted]);
            #1;
            if (ifc.in_ready) accepted++;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check("abort/accepted", ACC_W'(accepted), ACC_W'(7));
        ifc.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_state("abort");
        rst = 1'b1;
        @(negedge clk);
        run_frame("after_abort", 1'b0, 0, 1'b0, 1'b0);

        // Randomized frames, kernels, modes and handshake timing
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < NPIX; i++) frame_pix[i] = int'($urandom_range(0, 255));
            for (int i = 0; i < KK; i++) kern[i] = int'($urandom_range(0, 255));
            run_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)), 1, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
